// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle main FSM and the datapath.
// master = FSM side (drives enables/selects), slave = datapath side.
interface multicycle_ctrl_if;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  Op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, instr_done, illegal_op
  );

  modport slave (
    output Op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle datapath: walks each instruction
// through fetch/decode/execute/memory/write-back and drives every datapath
// enable and mux select. Outputs are Moore on the state register, with the
// fetch load enables and the store completion qualified by mem_ready.
module multicycle_ctrl (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IDLE   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q;
  state_t state_d;
  logic   op_legal;

  // Opcode support check, only meaningful while in DECODE.
  always_comb begin
    op_legal = 1'b0;
    case (bus.Op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
      default:                              op_legal = 1'b0;
    endcase
  end

  // State register; reset parks in IDLE so all enables drop immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; unused encodes fall back to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      // IR is stable here, so Op can be re-read to split load from store.
      MEMADR: state_d = (bus.Op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:  state_d = bus.mem_ready ? FETCH : MEMWR;
      EXEC:   state_d = RWB;
      MEMWB, RWB, BRANCH, JUMP: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Output decode; everything defaults low so IDLE and unlisted states are inert.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;
    bus.instr_done  = 1'b0;
    bus.illegal_op  = 1'b0;
    case (state_q)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      DECODE: begin
        bus.ALUSrcB    = 2'b11;
        bus.illegal_op = ~op_legal;
      end
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEMWB: begin
        bus.RegWrite   = 1'b1;
        bus.MemtoReg   = 1'b1;
        bus.instr_done = 1'b1;
      end
      MEMWR: begin
        bus.MemWrite   = 1'b1;
        bus.IorD       = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      RWB: begin
        bus.RegWrite   = 1'b1;
        bus.RegDst     = 1'b1;
        bus.instr_done = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
        bus.instr_done  = 1'b1;
      end
      JUMP: begin
        bus.PCWrite    = 1'b1;
        bus.PCSource   = 2'b10;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus pushes the expected
// control word for each cycle, a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca;
    logic [1:0] srcb, aop, psrc;
    logic       done, ill;
  } ctl_t;

  typedef struct {
    ctl_t  exp;
    string tag;
  } item_t;

  item_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic ctl_t sample();
    ctl_t s;
    s.st   = bus.state;
    s.pcw  = bus.PCWrite;
    s.pcwc = bus.PCWriteCond;
    s.iord = bus.IorD;
    s.mrd  = bus.MemRead;
    s.mwr  = bus.MemWrite;
    s.irw  = bus.IRWrite;
    s.m2r  = bus.MemtoReg;
    s.rdst = bus.RegDst;
    s.rwr  = bus.RegWrite;
    s.srca = bus.ALUSrcA;
    s.srcb = bus.ALUSrcB;
    s.aop  = bus.ALUOp;
    s.psrc = bus.PCSource;
    s.done = bus.instr_done;
    s.ill  = bus.illegal_op;
    return s;
  endfunction

  // Hand-written control word for each state, straight from the output table.
  function automatic ctl_t expect_for(input logic [3:0] st, input logic mr, input logic ill);
    ctl_t e;
    e = '0;
    e.st = st;
    case (st)
      4'd0: begin e.mrd = 1; e.srcb = 2'b01; e.irw = mr; e.pcw = mr; end
      4'd1: begin e.srcb = 2'b11; e.ill = ill; end
      4'd2: begin e.srca = 1; e.srcb = 2'b10; end
      4'd3: begin e.mrd = 1; e.iord = 1; end
      4'd4: begin e.rwr = 1; e.m2r = 1; e.done = 1; end
      4'd5: begin e.mwr = 1; e.iord = 1; e.done = mr; end
      4'd6: begin e.srca = 1; e.aop = 2'b10; end
      4'd7: begin e.rwr = 1; e.rdst = 1; e.done = 1; end
      4'd8: begin e.srca = 1; e.aop = 2'b01; e.pcwc = 1; e.psrc = 2'b01; e.done = 1; end
      4'd9: begin e.pcw = 1; e.psrc = 2'b10; e.done = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(input ctl_t got, input ctl_t exp, input string tag);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Monitor: compare whatever the stimulus queued for this cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      check(sample(), it.exp, it.tag);
    end
  end

  // One clock of stimulus with the state the DUT must be in during it.
  task automatic cyc(input logic [3:0] st, input logic [5:0] op, input logic mr,
                     input logic ill, input string tag);
    item_t it;
    bus.Op        = op;
    bus.mem_ready = mr;
    it.exp = expect_for(st, mr, ill);
    it.tag = tag;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    bus.Op        = 6'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc(4'd15, 6'h00, 1'b1, 1'b0, "rst_hold0");
    cyc(4'd15, 6'h00, 1'b1, 1'b0, "rst_hold1");
    rst_n = 1'b1;
    cyc(4'd15, 6'h00, 1'b1, 1'b0, "rst_rel_idle");

    // R-type: 0,1,6,7
    cyc(4'd0, 6'b000000, 1'b1, 1'b0, "r_fetch");
    cyc(4'd1, 6'b000000, 1'b1, 1'b0, "r_decode");
    cyc(4'd6, 6'b000000, 1'b1, 1'b0, "r_exec");
    cyc(4'd7, 6'b000000, 1'b1, 1'b0, "r_rwb");

    // lw with two wait cycles in MEMRD: 7 cycles total
    cyc(4'd0, 6'b100011, 1'b1, 1'b0, "lw_fetch");
    cyc(4'd1, 6'b100011, 1'b1, 1'b0, "lw_decode");
    cyc(4'd2, 6'b100011, 1'b1, 1'b0, "lw_memadr");
    cyc(4'd3, 6'b100011, 1'b0, 1'b0, "lw_memrd_w0");
    cyc(4'd3, 6'b100011, 1'b0, 1'b0, "lw_memrd_w1");
    cyc(4'd3, 6'b100011, 1'b1, 1'b0, "lw_memrd_rdy");
    cyc(4'd4, 6'b100011, 1'b1, 1'b0, "lw_memwb");

    // sw with three wait cycles in FETCH
    cyc(4'd0, 6'b101011, 1'b0, 1'b0, "sw_fetch_w0");
    cyc(4'd0, 6'b101011, 1'b0, 1'b0, "sw_fetch_w1");
    cyc(4'd0, 6'b101011, 1'b0, 1'b0, "sw_fetch_w2");
    cyc(4'd0, 6'b101011, 1'b1, 1'b0, "sw_fetch_rdy");
    cyc(4'd1, 6'b101011, 1'b1, 1'b0, "sw_decode");
    cyc(4'd2, 6'b101011, 1'b1, 1'b0, "sw_memadr");
    cyc(4'd5, 6'b101011, 1'b1, 1'b0, "sw_memwr");

    // beq then j, 3 cycles each; Op junk outside DECODE must not matter
    cyc(4'd0, 6'b111111, 1'b1, 1'b0, "beq_fetch");
    cyc(4'd1, 6'b000100, 1'b1, 1'b0, "beq_decode");
    cyc(4'd8, 6'b101011, 1'b1, 1'b0, "beq_branch");
    cyc(4'd0, 6'b000010, 1'b1, 1'b0, "j_fetch");
    cyc(4'd1, 6'b000010, 1'b1, 1'b0, "j_decode");
    cyc(4'd9, 6'b100011, 1'b1, 1'b0, "j_jump");

    // illegal opcode: 2 cycles, pulse in DECODE
    cyc(4'd0, 6'b111111, 1'b1, 1'b0, "ill_fetch");
    cyc(4'd1, 6'b111111, 1'b1, 1'b1, "ill_decode");

    // sw aborted by reset while waiting in MEMWR
    cyc(4'd0, 6'b101011, 1'b1, 1'b0, "sw2_fetch");
    cyc(4'd1, 6'b101011, 1'b1, 1'b0, "sw2_decode");
    cyc(4'd2, 6'b101011, 1'b1, 1'b0, "sw2_memadr");
    cyc(4'd5, 6'b101011, 1'b0, 1'b0, "sw2_memwr_wait");
    bus.mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check(sample(), expect_for(4'd15, 1'b0, 1'b0), "async_rst_midcycle");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(4'd15, 6'b000000, 1'b1, 1'b0, "rst2_rel_idle");
    cyc(4'd0,  6'b000000, 1'b1, 1'b0, "rst2_fetch");
    cyc(4'd1,  6'b000000, 1'b1, 1'b0, "rst2_decode");
    cyc(4'd6,  6'b000000, 1'b1, 1'b0, "rst2_exec");
    cyc(4'd7,  6'b000000, 1'b1, 1'b0, "rst2_rwb");
    cyc(4'd0,  6'b000000, 1'b1, 1'b0, "rst2_next_fetch");

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle datapath variant. It sequences each instruction through fetch, decode, execute, memory and write-back cycles. It drives every datapath enable and mux select, and produces the 2-bit `ALUOp` consumed by the ALU control decoder. The decoder combines `ALUOp` with the funct field to select the ALU operation.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `Op` in 6: opcode, IR[31:26], from the instruction register; sampled in DECODE.
- `mem_ready` in 1: memory handshake, high when the current read or write completes this cycle.
- `PCWrite` out 1: unconditional PC load.
- `PCWriteCond` out 1: PC load qualified by ALU Zero, which is ANDed outside this block.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead` out 1: memory read request.
- `MemWrite` out 1: memory write request.
- `IRWrite` out 1: instruction register load.
- `MemtoReg` out 1: write-back data select; 1 = MDR, 0 = ALUOut.
- `RegDst` out 1: destination register select; 1 = rd, 0 = rt.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 1: ALU A select; 0 = PC, 1 = A register.
- `ALUSrcB` out 2: ALU B select; 00 = B register, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `ALUOp` out 2: 00 = add, 01 = subtract, 10 = use funct.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state` out 4: current state code, for debug.
- `instr_done` out 1: one-cycle pulse in the last cycle of each instruction.
- `illegal_op` out 1: one-cycle pulse when an unsupported opcode is decoded.

## Operation
- State codes:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, RWB = 7, BRANCH = 8, JUMP = 9, IDLE = 15.
  - Codes 10–14 are unused and go to FETCH on the next edge.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010.
- Transitions:
  - IDLE -> FETCH unconditionally.
  - FETCH -> DECODE when `mem_ready` = 1; otherwise stay in FETCH.
  - DECODE dispatches on `Op`:
    - lw or sw -> MEMADR.
    - R-type -> EXEC.
    - beq -> BRANCH.
    - j -> JUMP.
    - Any other opcode -> FETCH, with `illegal_op` = 1.
  - MEMADR -> MEMRD for lw, MEMWR for sw. `Op` is re-read here; the IR is stable.
  - MEMRD -> MEMWB when `mem_ready`; otherwise stay in MEMRD.
  - MEMWR -> FETCH when `mem_ready`; otherwise stay in MEMWR.
  - EXEC -> RWB.
  - MEMWB, RWB, BRANCH and JUMP -> FETCH.
- Outputs are Moore, decoded from `state`, except that `IRWrite`, `PCWrite` (in FETCH) and `instr_done` are also qualified by `mem_ready` where noted. Every output not listed for a state is 0.
- FETCH:
  - `MemRead` = 1, `IorD` = 0, `ALUSrcA` = 0, `ALUSrcB` = 01, `ALUOp` = 00, `PCSource` = 00.
  - `IRWrite` = `PCWrite` = `mem_ready`.
- DECODE: `ALUSrcA` = 0, `ALUSrcB` = 11, `ALUOp` = 00.
- MEMADR: `ALUSrcA` = 1, `ALUSrcB` = 10, `ALUOp` = 00.
- MEMRD: `MemRead` = 1, `IorD` = 1.
- MEMWB: `RegWrite` = 1, `MemtoReg` = 1, `RegDst` = 0.
- MEMWR: `MemWrite` = 1, `IorD` = 1; `instr_done` = `mem_ready`.
- EXEC: `ALUSrcA` = 1, `ALUSrcB` = 00, `ALUOp` = 10.
- RWB: `RegWrite` = 1, `RegDst` = 1, `MemtoReg` = 0.
- BRANCH: `ALUSrcA` = 1, `ALUSrcB` = 00, `ALUOp` = 01, `PCWriteCond` = 1, `PCSource` = 01.
- JUMP: `PCWrite` = 1, `PCSource` = 10.
- `instr_done` = 1 in MEMWB, RWB, BRANCH and JUMP, and in MEMWR qualified by `mem_ready`.
- IDLE: all outputs 0.

## Timing
- Reset:
  - `rst_n` low forces `state` = IDLE immediately (asynchronous), so all control outputs read 0.
  - The first rising edge after release enters IDLE -> FETCH; the first FETCH cycle is cycle 1 after release.
  - Reset asserted mid-instruction aborts it at once. No write enable may stay high after `rst_n` falls.
- Cycle counts from FETCH entry to the next FETCH entry, with `mem_ready` held at 1:
  - R-type 4, lw 5, sw 4, beq 3, j 3.
  - Illegal opcode 2.
- Each cycle of `mem_ready` = 0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Request outputs (`MemRead`/`MemWrite`/`IorD`) hold steady throughout the wait.
- `Op` is ignored outside DECODE and MEMADR.

## Test plan
- Reset, then R-type (`Op` = 000000), `mem_ready` = 1:
  - `state` goes 15, 0, 1, 6, 7, 0.
  - `ALUOp` = 10 in EXEC; `RegWrite` = `RegDst` = 1 in RWB; `instr_done` pulses once.
- lw with `mem_ready` low for 2 cycles in MEMRD:
  - 7-cycle instruction.
  - `MemRead` = `IorD` = 1 for 3 cycles.
  - `RegWrite` = `MemtoReg` = 1 in MEMWB.
- sw with `mem_ready` low for 3 cycles in FETCH:
  - `IRWrite`/`PCWrite` stay 0 until ready.
  - `MemWrite` = 1 in MEMWR.
  - `instr_done` pulses in MEMWR.
- beq then j:
  - BRANCH shows `ALUOp` = 01, `PCWriteCond` = 1, `PCSource` = 01.
  - JUMP shows `PCWrite` = 1, `PCSource` = 10.
  - Each takes 3 cycles.
- `Op` = 111111: `illegal_op` = 1 in DECODE, then FETCH; no write enable is asserted.
- `rst_n` pulsed low during MEMWR: `MemWrite` drops within the same cycle, `state` = 15, and the FSM resumes at FETCH.
